// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the memory access unit.
// Size codes, FSM states, the registered request payload and the store-lane merge.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Replace the addressed little-endian lane of word with the low bits of wdata.
  function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [1:0]        a,
                                                    input logic [1:0]        size);
    logic [DATA_W-1:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (a)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (a[1]) r[31:16] = wdata[15:0];
      else      r[15:0]  = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select with sign/zero extension to a full 32-bit result.
module load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = 8'h00;
    case (addr)
      2'd0:    byte_c = word[7:0];
      2'd1:    byte_c = word[15:8];
      2'd2:    byte_c = word[23:16];
      default: byte_c = word[31:24];
    endcase
    half_c = addr[1] ? word[31:16] : word[15:0];

    data = word;
    case (size)
      SZ_BYTE: data = {{24{is_signed & byte_c[7]}}, byte_c};
      SZ_HALF: data = {{16{is_signed & half_c[15]}}, half_c};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store front end for a single-port synchronous word RAM.
// Sub-word stores are done as read-modify-write; misaligned requests return an error.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned AW = ADDR_W + 2;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            err_q, err_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     load_data_c;
  logic            bad_c;

  // Address bits above the RAM range wrap and are intentionally dropped.
  logic unused_addr_c;
  assign unused_addr_c = ^req_addr[31:AW];

  load_ext u_load_ext (
    .word      (word_q),
    .addr      (addr_q[1:0]),
    .size      (req_q.size),
    .is_signed (req_q.sgn),
    .data      (load_data_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      word_q  <= word_d;
    end
  end

  // Next state; outputs depend only on state and registered request fields.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    err_d     = err_q;
    word_d    = word_q;
    bad_c     = is_bad_req(req_size, req_addr[1:0]);
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q[AW-1:2];
    mem_wdata = merge_store(word_q, req_q.wdata, addr_q[1:0], req_q.size);

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d  = '{we: req_we, size: req_size, sgn: req_signed, wdata: req_wdata};
          addr_d = req_addr[AW-1:0];
          err_d  = bad_c;
          if (bad_c)                              state_d = RESP;
          else if (req_we && req_size == SZ_WORD) state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ: begin
        mem_en  = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        word_d  = mem_rdata;
        state_d = req_q.we ? WRITE : RESP;
      end
      WRITE: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !req_q.we) rsp_rdata = load_data_c;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural single-port RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] ram [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0, en_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
  int lat, s0, s1;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
    if (mem_en && mem_we)        we_cnt  <= we_cnt + 1;
    if (mem_en)                  en_cnt  <= en_cnt + 1;
    if (rsp_valid)               rsp_cnt <= rsp_cnt + 1;
    if (req_valid && req_ready)  acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  // Issue one request from IDLE, then wait (bounded) for the response pulse.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
    int n;
    @(negedge clk);
    drive(we, sz, sg, a, wd);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, rsp_rdata, exp_data);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #2;
    check("rst_ready",  32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(rsp_valid), 32'd0);
    check("rst_rdata",  rsp_rdata, 32'd0);
    check("rst_err",    32'(rsp_err), 32'd0);
    check("rst_en",     32'(mem_en), 32'd0);
    check("rst_we",     32'(mem_we), 32'd0);
    check("rst_addr",   32'(mem_addr), 32'd0);
    check("rst_wdata",  mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Byte loads with sign/zero extension
    poke(10'd1, 32'h12F45678);
    txn("lb_s5", 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 3, 32'h00000056, 1'b0);
    txn("lb_s6", 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 3, 32'hFFFFFFF4, 1'b0);
    txn("lb_s7", 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 3, 32'h00000012, 1'b0);
    txn("lb_u4", 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 3, 32'h00000078, 1'b0);

    // Sub-word stores via read-modify-write
    poke(10'd0, 32'hAABBCCDD);
    s0 = we_cnt;
    txn("sh_2", 1'b1, 2'b01, 1'b0, 32'h2, 32'h00001234, 4, 32'h0, 1'b0);
    check("sh_ram", ram[0], 32'h1234CCDD);
    check("sh_wecnt", 32'(we_cnt - s0), 32'd1);
    txn("sb_1", 1'b1, 2'b00, 1'b0, 32'h1, 32'hFFFFFF5A, 4, 32'h0, 1'b0);
    check("sb_ram", ram[0], 32'h12345ADD);

    // Error requests never touch the RAM
    s0 = en_cnt;
    txn("lw_mis", 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 1, 32'h0, 1'b1);
    txn("lh_mis", 1'b0, 2'b01, 1'b1, 32'h1, 32'h0, 1, 32'h0, 1'b1);
    txn("sz_ill", 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
    check("err_en", 32'(en_cnt - s0), 32'd0);
    check("err_ram", ram[0], 32'h12345ADD);

    // Halfword and word loads
    poke(10'd2, 32'h8001FFFF);
    txn("lh_uA", 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 3, 32'h00008001, 1'b0);
    txn("lh_sA", 1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 3, 32'hFFFF8001, 1'b0);
    txn("lh_s8", 1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 3, 32'hFFFFFFFF, 1'b0);
    txn("lh_u8", 1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 3, 32'h0000FFFF, 1'b0);
    txn("lw_s8", 1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 3, 32'h8001FFFF, 1'b0);

    // Back-to-back word stores with req_valid held high
    s0 = acc_cnt;
    s1 = we_cnt;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h00001010, 32'hDEADBEEF);
    @(negedge clk);
    check("b2b_busy", 32'(req_ready), 32'd0);
    req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("b2b_rsp1", 32'(rsp_valid), 32'd1);
    check("b2b_busy2", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready", 32'(req_ready), 32'd1);
    check("b2b_acc1", 32'(acc_cnt - s0), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_rsp2", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("b2b_acc2", 32'(acc_cnt - s0), 32'd2);
    check("b2b_we", 32'(we_cnt - s1), 32'd2);
    check("b2b_ram4", ram[4], 32'hDEADBEEF);
    check("b2b_ram5", ram[5], 32'hCAFEF00D);
    txn("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h00001014, 32'h0, 3, 32'hCAFEF00D, 1'b0);

    // Reset while a byte store sits in CAPTURE
    poke(10'd6, 32'h11223344);
    s0 = we_cnt;
    s1 = rsp_cnt;
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 32'h18, 32'h000000AA);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rc_ready", 32'(req_ready), 32'd1);
    check("rc_we", 32'(mem_we), 32'd0);
    check("rc_en", 32'(mem_en), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rc_wecnt", 32'(we_cnt - s0), 32'd0);
    check("rc_rsp", 32'(rsp_cnt - s1), 32'd0);
    check("rc_ram", ram[6], 32'h11223344);
    txn("rc_after", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 3, 32'h11223344, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, default 10, word-address width of the data RAM (1024 words).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word data in low bits.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-size request, valid with rsp_valid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write strobe, qualified by mem_en.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write word.
- mem_rdata  in  32  RAM read word, valid the cycle after a read strobe.
REQ-003 SHALL use clock clk and reset reset; reset is asynchronous and active-low, and the block has one clock.

Function
REQ-004 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, registering all req_* fields.
REQ-005 SHALL drive req_ready=1 only in IDLE; req_valid outside IDLE is ignored, not queued.
REQ-006 SHALL use FSM states IDLE, READ, CAPTURE, WRITE, RESP.
REQ-007 SHALL flag an error for: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-008 SHALL handle an error request as IDLE->RESP, with rsp_err=1, rsp_rdata=0, and no mem_en.
REQ-009 SHALL handle a load as IDLE->READ->CAPTURE->RESP->IDLE, with rsp_valid 3 cycles after the accept edge.
REQ-010 SHALL handle a word store as IDLE->WRITE->RESP->IDLE.
REQ-011 SHALL handle a byte/halfword store as a read-modify-write, IDLE->READ->CAPTURE->WRITE->RESP->IDLE.
REQ-012 SHALL, in READ, drive mem_en=1 and mem_we=0; in WRITE, drive mem_en=1 and mem_we=1; in all other states, drive mem_en=0 and mem_we=0.
REQ-013 SHALL drive mem_addr = registered addr[ADDR_W+1:2]; higher address bits are ignored (wrap-around).
REQ-014 SHALL capture mem_rdata in CAPTURE into an internal word register.
REQ-015 SHALL use little-endian lanes: byte k=addr[1:0] occupies bits [8k+7:8k]; halfword h=addr[1] occupies bits [16h+15:16h].
REQ-016 SHALL, for sub-word stores, replace only the addressed lane with the corresponding low bits of wdata and preserve all other bytes of the captured word.
REQ-017 SHALL extend a load byte/halfword to 32 bits per req_signed; word loads ignore req_signed.
REQ-018 SHALL hold rsp_valid=1 for exactly one cycle (RESP); rsp_rdata/rsp_err are valid only then and 0 otherwise.
REQ-019 SHALL accept a new request in the cycle after RESP (back-to-back throughput: one request per FSM pass).

Reset
REQ-020 SHALL, when reset=0, force state=IDLE immediately regardless of clk.
REQ-021 SHALL reset outputs to: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 SHALL, on reset mid-operation, abandon the transaction: no response, and no write of a partially merged word.
REQ-023 SHALL clear all request/capture registers on reset.

Structure
REQ-024 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings in a shared package.
REQ-025 SHALL implement lane select plus sign/zero extension as the combinational sub-module load_ext (inputs: word, addr[1:0], size, signed; output: 32-bit).
REQ-026 SHALL keep all outputs registered or decoded from state and registers only; no combinational path from req_* to mem_*.

Verification
REQ-027 Load byte signed: RAM[0x4>>2]=0x12F45678, addr=0x5, size=00, signed=1 -> rsp_rdata=0x00000056; addr=0x6 -> 0xFFFFFFF4; rsp_valid 3 cycles after accept.
REQ-028 Store halfword: RAM word=0xAABBCCDD, addr=0x2, wdata=0x00001234 -> RAM word becomes 0x1234CCDD; exactly one mem_we pulse.
REQ-029 Misaligned: word load addr=0x3 -> next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, mem_en never asserted.
REQ-030 Back-to-back: two consecutive word stores with req_valid held high -> the second is accepted only after the first RESP, and both addresses are written correctly.
REQ-031 Reset in CAPTURE of a byte store -> mem_we stays 0, no rsp_valid, req_ready=1 immediately, RAM unchanged.
REQ-032 Halfword load unsigned: RAM word=0x8001FFFF, addr=0x2, signed=0 -> rsp_rdata=0x00008001; signed=1 -> 0xFFFF8001.
